spi_tx_encoder: RTL and testbench

- SPI slave transmit side of the robot-controller link.
- Accepts {address, data} status words from FPGA logic and queues them in a small FIFO.
- Builds each 16-bit frame as {crc[3:0], addr[3:0], data[7:0]} and shifts it out on MISO, MSB first, using SPI mode 0.
- Uses the same practice CRC as the receive path. The host decodes frames with the same rules it uses for command frames.

---
 rtl/spi_tx_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_spi_tx_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_encoder.sv
// spi_tx_encoder: SPI slave transmit side of the robot-controller link.
// Status words {addr, data} are queued in a small FIFO, wrapped into a
// 16-bit {crc, addr, data} frame and shifted out on MISO, MSB first, SPI mode 0.
// SCLK and CS_N are asynchronous and are oversampled on fpga_clock.
module spi_tx_encoder #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] IDLE_ADDR  = 4'h3
) (
    input  logic                          fpga_clock,
    input  logic                          reset,
    input  logic                          spi_clock,
    input  logic                          cs_n,
    output logic                          miso,
    output logic                          miso_oe,
    input  logic                          tx_valid,
    input  logic [3:0]                    tx_addr,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          tx_sent,
    output logic                          tx_abort,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            LW         = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [4:0]    LAST_RISE  = 5'd15;
    localparam logic [4:0]    FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Practice CRC shared with the receive path; frame = {crc, addr, data}.
    function automatic logic [15:0] build_frame(input logic [11:0] w);
        logic [3:0] crc;
        crc[3] = w[11] ^ w[7] ^ w[5] ^ w[3];
        crc[2] = w[10] ^ w[5] ^ w[3] ^ w[1];
        crc[1] = w[9]  ^ w[6] ^ w[4] ^ w[2];
        crc[0] = w[8]  ^ w[4] ^ w[2] ^ w[0];
        return {crc, w};
    endfunction

    // Synchronizer chains: _p0/_p1 resynchronize, _p2 is the edge-detect history.
    logic r_sclk_p0, r_sclk_p1, r_sclk_p2;
    logic r_cs_p0,   r_cs_p1,   r_cs_p2;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    // Word queue.
    logic [11:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          w_push, w_pop, w_empty;
    logic [11:0]   w_head;

    // Frame engine.
    state_t      r_state, w_state_nxt;
    logic [15:0] r_shift, w_shift_nxt, w_frame_sel;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic        r_from_fifo, w_from_fifo_nxt;
    logic        r_have_word, w_have_word_nxt;
    logic        r_tx_sent, w_tx_sent_nxt;
    logic        r_tx_abort, w_tx_abort_nxt;

    // Bring SCLK and CS_N into the fpga_clock domain; reset parks them deselected.
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            r_sclk_p0 <= 1'b0;
            r_sclk_p1 <= 1'b0;
            r_sclk_p2 <= 1'b0;
            r_cs_p0   <= 1'b1;
            r_cs_p1   <= 1'b1;
            r_cs_p2   <= 1'b1;
        end else begin
            r_sclk_p0 <= spi_clock;
            r_sclk_p1 <= r_sclk_p0;
            r_sclk_p2 <= r_sclk_p1;
            r_cs_p0   <= cs_n;
            r_cs_p1   <= r_cs_p0;
            r_cs_p2   <= r_cs_p1;
        end
    end

    assign w_sclk_rise =  r_sclk_p1 & ~r_sclk_p2;
    assign w_sclk_fall = ~r_sclk_p1 &  r_sclk_p2;
    assign w_cs_rise   =  r_cs_p1   & ~r_cs_p2;
    assign w_cs_fall   = ~r_cs_p1   &  r_cs_p2;

    assign w_empty    = (r_count == '0);
    assign tx_ready   = (r_count != FULL_LEVEL);
    assign w_push     = tx_valid & tx_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_level = r_count;

    // Queue storage: data only, so no reset is needed.
    always_ff @(posedge fpga_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tx_addr, tx_data};
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop keep the level.
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame chosen for LOAD: the queue head if it was present when CS_N fell,
    // otherwise the idle frame. The snapshot keeps a push that races the CS_N
    // fall out of the frame already being set up.
    assign w_frame_sel = r_have_word ? build_frame(w_head)
                                     : build_frame({IDLE_ADDR, 8'h00});

    // Frame engine state registers (control only).
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_from_fifo <= 1'b0;
            r_have_word <= 1'b0;
            r_tx_sent   <= 1'b0;
            r_tx_abort  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_from_fifo <= w_from_fifo_nxt;
            r_have_word <= w_have_word_nxt;
            r_tx_sent   <= w_tx_sent_nxt;
            r_tx_abort  <= w_tx_abort_nxt;
        end
    end

    // Shift register is pure data; its contents only matter in LOAD/SHIFT.
    always_ff @(posedge fpga_clock) begin
        r_shift <= w_shift_nxt;
    end

    // Next-state logic: load, shift on SCLK falls, count SCLK rises, finish or abort.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_from_fifo_nxt = r_from_fifo;
        w_have_word_nxt = r_have_word;
        w_tx_sent_nxt   = 1'b0;
        w_tx_abort_nxt  = 1'b0;
        w_pop           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_have_word_nxt = ~w_empty;
                    w_state_nxt     = S_LOAD;
                end
            end

            S_LOAD: begin
                w_shift_nxt     = w_frame_sel;
                w_from_fifo_nxt = r_have_word;
                w_bit_cnt_nxt   = '0;
                w_state_nxt     = S_SHIFT;
            end

            S_SHIFT: begin
                if (w_sclk_rise && (r_bit_cnt == LAST_RISE)) begin
                    // 16th rise wins over a coincident CS_N rise: the frame is complete.
                    w_bit_cnt_nxt = FRAME_BITS;
                    w_pop         = r_from_fifo;
                    w_tx_sent_nxt = r_from_fifo;
                    w_state_nxt   = w_cs_rise ? S_IDLE : S_DONE;
                end else if (w_cs_rise) begin
                    // Head stays queued and is resent in full next frame.
                    w_tx_abort_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (w_sclk_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end else if (w_sclk_fall && (r_bit_cnt < FRAME_BITS)) begin
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                end
            end

            S_DONE: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign miso_oe  = (r_state != S_IDLE);
    assign miso     = (r_state == S_LOAD)  ? w_frame_sel[15] :
                      (r_state == S_SHIFT) ? r_shift[15]     : 1'b0;
    assign tx_sent  = r_tx_sent;
    assign tx_abort = r_tx_abort;

endmodule

// File: tb/tb_spi_tx_encoder.sv
// tb_spi_tx_encoder: SPI-master driven bench with a word-queue reference model
// and a frame scoreboard checked by an independent monitor.
module tb_spi_tx_encoder;

    localparam int         DEPTH  = 4;
    localparam logic [3:0] IDLE_A = 4'h3;
    localparam int         HALF   = 6;

    logic       fpga_clock = 1'b0;
    logic       reset      = 1'b1;
    logic       spi_clock  = 1'b0;
    logic       cs_n       = 1'b1;
    logic       miso, miso_oe;
    logic       tx_valid   = 1'b0;
    logic [3:0] tx_addr    = 4'h0;
    logic [7:0] tx_data    = 8'h00;
    logic       tx_ready, tx_sent, tx_abort;
    logic [2:0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    int m_tests = 0;
    int m_fail  = 0;
    int sent_cnt  = 0;
    int abort_cnt = 0;

    logic [11:0] model_q[$];
    logic [15:0] exp_q[$];

    logic [15:0] cap      = 16'h0;
    int          cap_bits = 0;
    int          oe_bad   = 0;
    event        frame_end;

    spi_tx_encoder #(.FIFO_DEPTH(DEPTH), .IDLE_ADDR(IDLE_A)) dut (
        .fpga_clock (fpga_clock),
        .reset      (reset),
        .spi_clock  (spi_clock),
        .cs_n       (cs_n),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_valid   (tx_valid),
        .tx_addr    (tx_addr),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_sent    (tx_sent),
        .tx_abort   (tx_abort),
        .fifo_level (fifo_level)
    );

    always #5 fpga_clock = ~fpga_clock;

    // Frame = {crc, w}; each crc bit is the parity of w over a fixed tap mask.
    function automatic logic [15:0] ref_frame(input logic [11:0] w);
        logic [3:0] c;
        c[3] = ^(w & 12'h8A8);
        c[2] = ^(w & 12'h42A);
        c[1] = ^(w & 12'h254);
        c[0] = ^(w & 12'h115);
        return {c, w};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge fpga_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters, sampled mid-cycle.
    always @(negedge fpga_clock) begin
        if (tx_sent === 1'b1)  sent_cnt  <= sent_cnt + 1;
        if (tx_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    // Master receive shifter: sample MISO on each SCLK rise, clear on CS_N fall.
    always @(posedge spi_clock or negedge cs_n) begin
        if (spi_clock) begin
            cap      <= {cap[14:0], miso};
            cap_bits <= cap_bits + 1;
            if (miso_oe !== 1'b1) oe_bad <= oe_bad + 1;
        end else begin
            cap      <= 16'h0;
            cap_bits <= 0;
            oe_bad   <= 0;
        end
    end

    // Scoreboard monitor: every complete 16-bit frame pops one expected frame.
    always begin
        logic [15:0] exp_word;
        @(frame_end);
        if (cap_bits == 16) begin
            m_tests++;
            if (exp_q.size() == 0) begin
                m_fail++;
                $display("FAIL frame_unexpected: got %04h, expected no frame", cap);
            end else begin
                exp_word = exp_q.pop_front();
                if (cap !== exp_word) begin
                    m_fail++;
                    $display("FAIL frame_data: got %04h, expected %04h", cap, exp_word);
                end
                m_tests++;
                if (oe_bad != 0) begin
                    m_fail++;
                    $display("FAIL frame_miso_oe: got %0d low samples, expected 0", oe_bad);
                end
            end
        end
    end

    task automatic push_word(input logic [3:0] a, input logic [7:0] d);
        tx_valid = 1'b1;
        tx_addr  = a;
        tx_data  = d;
        check("tx_ready", 32'(tx_ready), 32'(model_q.size() < DEPTH));
        if (model_q.size() < DEPTH) model_q.push_back({a, d});
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Drive one mode-0 transaction of 'rises' SCLK rises. 'together' raises CS_N
    // with the last rise; 'rst_mid' pulses reset after 9 rises.
    task automatic run_frame(input int rises, input bit together, input bit rst_mid);
        int s0, a0;
        cs_n = 1'b0;
        tick(HALF + 2);
        for (int i = 0; i < rises; i++) begin
            if (rst_mid && i == 9) begin
                s0 = sent_cnt;
                a0 = abort_cnt;
                reset = 1'b1;
                cs_n  = 1'b1;
                tick(1);
                reset = 1'b0;
                check("rst_miso_oe", 32'(miso_oe), 32'd0);
                check("rst_level", 32'(fifo_level), 32'd0);
                check("rst_ready", 32'(tx_ready), 32'd1);
                model_q.delete();
                tick(8);
                check("rst_no_sent", 32'(sent_cnt - s0), 32'd0);
                check("rst_no_abort", 32'(abort_cnt - a0), 32'd0);
                ->frame_end;
                tick(1);
                return;
            end
            spi_clock = 1'b1;
            if (together && i == rises - 1) cs_n = 1'b1;
            tick(HALF);
            spi_clock = 1'b0;
            tick(HALF);
        end
        if (!together) begin
            tick(2);
            cs_n = 1'b1;
        end
        tick(8);
        ->frame_end;
        tick(1);
    endtask

    task automatic full_frame(input bit together, input string tag,
                              input bit use_const, input logic [15:0] cval);
        int s0, a0;
        bit had;
        s0  = sent_cnt;
        a0  = abort_cnt;
        had = (model_q.size() > 0);
        if (use_const)  exp_q.push_back(cval);
        else if (had)   exp_q.push_back(ref_frame(model_q[0]));
        else            exp_q.push_back(ref_frame({IDLE_A, 8'h00}));
        run_frame(16, together, 1'b0);
        if (had) void'(model_q.pop_front());
        check({tag, "_sent"}, 32'(sent_cnt - s0), 32'(had));
        check({tag, "_abort"}, 32'(abort_cnt - a0), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'(model_q.size()));
    endtask

    task automatic abort_frame(input int rises, input string tag);
        int s0, a0;
        s0 = sent_cnt;
        a0 = abort_cnt;
        run_frame(rises, 1'b0, 1'b0);
        check({tag, "_abort"}, 32'(abort_cnt - a0), 32'd1);
        check({tag, "_sent"}, 32'(sent_cnt - s0), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'(model_q.size()));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_miso_oe", 32'(miso_oe), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_sent", 32'(tx_sent), 32'd0);
        check("reset_abort", 32'(tx_abort), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);

        // Single word.
        push_word(4'h5, 8'hA7);
        check("d1_level_in", 32'(fifo_level), 32'd1);
        tick(2);
        full_frame(1'b0, "d1", 1'b1, 16'h75A7);

        // Empty queue: idle frame.
        full_frame(1'b0, "d2_idle", 1'b1, 16'h3300);

        // Two words in order.
        push_word(4'h5, 8'hA7);
        push_word(4'hF, 8'h00);
        check("d3_level", 32'(fifo_level), 32'd2);
        tick(2);
        full_frame(1'b0, "d3a", 1'b1, 16'h75A7);
        full_frame(1'b0, "d3b", 1'b1, 16'hFF00);

        // Overfill: fifth push dropped.
        for (int k = 1; k <= DEPTH + 1; k++) push_word(4'(k), 8'(k * 17));
        check("d4_level_full", 32'(fifo_level), 32'(DEPTH));
        check("d4_ready_full", 32'(tx_ready), 32'd0);
        tick(2);
        for (int k = 0; k < DEPTH; k++) full_frame(1'b0, "d4_drain", 1'b0, 16'h0);

        // Abort after 7 rises, then full retransmission.
        push_word(4'h5, 8'hA7);
        tick(2);
        abort_frame(7, "d5");
        full_frame(1'b0, "d5_retry", 1'b1, 16'h75A7);

        // Reset during bit 9 clears the queue.
        push_word(4'h9, 8'h3C);
        tick(2);
        run_frame(16, 1'b0, 1'b1);
        tick(2);
        full_frame(1'b0, "d6_after_rst", 1'b1, 16'h3300);

        // CS_N rise together with the 16th SCLK rise completes the frame.
        push_word(4'h5, 8'hA7);
        tick(2);
        full_frame(1'b1, "d7_together", 1'b1, 16'h75A7);
        full_frame(1'b0, "d7_next", 1'b1, 16'h3300);

        // Randomized traffic against the queue model.
        for (int it = 0; it < 30; it++) begin
            int np, kind;
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++)
                push_word(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            tick(2);
            kind = $urandom_range(0, 9);
            if (kind < 2)       abort_frame($urandom_range(1, 15), "r_abort");
            else if (kind == 2) full_frame(1'b1, "r_together", 1'b0, 16'h0);
            else                full_frame(1'b0, "r_full", 1'b0, 16'h0);
        end

        tick(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests + m_tests, n_fail + m_fail);
        $finish;
    end

endmodule
